// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the uart_rx controller: register map, FSM
// encoding, STATUS/CTRL bit positions and default baud settings.
package uart_ctrl_pkg;

  // Register addresses on the CPU bus
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_BAUD   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // Controller sequencing states
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } ctrl_state_t;

  // STATUS register bit positions
  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_RUNNING   = 3;
  localparam int STAT_COUNT_LSB = 8;

  // CTRL register bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  // Baud divisor defaults (50 MHz / 115200 at reset)
  localparam int unsigned BAUD_RESET_DEF = 434;
  localparam int unsigned BAUD_MIN_DEF   = 4;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// CPU-side register bus of the uart_rx controller.
interface uart_rx_ctrl_if;
  logic        sel;
  logic        wr;
  logic        rd;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, wr, rd, addr, wdata, input rdata);
  modport slave  (input sel, wr, rd, addr, wdata, output rdata);
endinterface

// File: rtl/uart_rx_ctrl_fifo.sv
// Receive byte FIFO. Pop-then-push ordering lets a full FIFO accept a
// push in the same cycle as a pop; flush wins over both.
// DEPTH must be a power of two, at least 2, so pointers wrap naturally.
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       i_Clock,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [7:0]                 i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [7:0]                 o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & ~w_empty & ~i_flush;
  assign w_push  = i_push & ~i_flush & (~w_full | w_pop);

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;
  assign o_drop  = i_push & ~i_flush & w_full & ~w_pop;

  // Storage write; contents are qualified by count, so no reset.
  // NOTE: the memory array is left unreset on purpose -- a reset would turn
  // it into flops with a wide reset tree; empty/count already mask stale data.
  always_ff @(posedge i_Clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy tracking.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_Clock) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx controller: owns the baud divisor and its load pulse, buffers
// received bytes and exposes DATA/STATUS/BAUD/CTRL registers to the CPU.
module uart_rx_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter int unsigned BAUD_RESET = BAUD_RESET_DEF,
  parameter int unsigned BAUD_MIN   = BAUD_MIN_DEF
) (
  input  logic               i_Clock,
  input  logic               rst,
  uart_rx_ctrl_if.slave      bus,
  input  logic               rx_dv,
  input  logic [7:0]         rx_byte,
  output logic [31:0]        clks_per_bit,
  output logic               ld_clks_per_bit,
  output logic               irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ctrl_state_t r_state;
  logic        r_ld;
  logic [31:0] r_baud;
  logic        r_en;
  logic        r_irq_en;
  logic        r_ovr;
  logic        r_irq;
  logic [31:0] r_rdata;

  logic          w_wr;
  logic          w_rd;
  logic          w_wr_ctrl;
  logic          w_wr_status;
  logic          w_wr_baud_ok;
  logic          w_flush;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_drop;
  logic [31:0]   w_status;

  assign w_wr         = bus.sel & bus.wr;
  assign w_rd         = bus.sel & bus.rd;
  assign w_wr_ctrl    = w_wr & (bus.addr == ADDR_CTRL);
  assign w_wr_status  = w_wr & (bus.addr == ADDR_STATUS);
  assign w_wr_baud_ok = w_wr & (bus.addr == ADDR_BAUD) & (bus.wdata >= 32'(BAUD_MIN));
  assign w_flush      = w_wr_ctrl & bus.wdata[CTRL_FLUSH];
  assign w_push       = rx_dv & (r_state != ST_OFF);
  assign w_pop        = w_rd & (bus.addr == ADDR_DATA);

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_Clock (i_Clock),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (rx_byte),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_drop  (w_drop)
  );

  // STATUS word assembled from live flags.
  // NOTE: default every always_comb output first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    w_status                         = '0;
    w_status[STAT_COUNT_LSB +: CW]   = w_count;
    w_status[STAT_RUNNING]           = (r_state != ST_OFF);
    w_status[STAT_OVERRUN]           = r_ovr;
    w_status[STAT_FULL]              = w_full;
    w_status[STAT_NOT_EMPTY]         = ~w_empty;
  end

  // Sequencer: divisor register, OFF/LOAD/RUN and the registered load pulse.
  always_ff @(posedge i_Clock) begin
    if (rst) begin
      r_state <= ST_OFF;
      r_ld    <= 1'b0;
      r_baud  <= 32'(BAUD_RESET);
    end else begin
      r_ld <= 1'b0;
      if (w_wr_baud_ok) r_baud <= bus.wdata;
      case (r_state)
        ST_OFF: begin
          if (w_wr_ctrl && bus.wdata[CTRL_EN]) begin
            r_state <= ST_LOAD;
            r_ld    <= 1'b1;
          end
        end
        ST_LOAD: r_state <= ST_RUN;
        ST_RUN: begin
          if (w_wr_ctrl && !bus.wdata[CTRL_EN]) begin
            r_state <= ST_OFF;
          end else if (w_wr_baud_ok) begin
            r_state <= ST_LOAD;
            r_ld    <= 1'b1;
          end
        end
        default: r_state <= ST_OFF;
      endcase
    end
  end

  // Control bits, sticky overrun (a new overrun beats a clear) and irq.
  always_ff @(posedge i_Clock) begin
    if (rst) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_ovr    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= bus.wdata[CTRL_EN];
        r_irq_en <= bus.wdata[CTRL_IRQ_EN];
      end
      if (w_drop)
        r_ovr <= 1'b1;
      else if (w_wr_status && bus.wdata[STAT_OVERRUN])
        r_ovr <= 1'b0;
      r_irq <= r_irq_en & (~w_empty | r_ovr);
    end
  end

  // Registered read data; reflects pre-write state and holds when idle.
  always_ff @(posedge i_Clock) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd) begin
      case (bus.addr)
        ADDR_DATA:   r_rdata <= w_empty ? 32'd0 : {24'd0, w_head};
        ADDR_STATUS: r_rdata <= w_status;
        ADDR_BAUD:   r_rdata <= r_baud;
        ADDR_CTRL:   r_rdata <= {30'd0, r_irq_en, r_en};
        default:     r_rdata <= '0;
      endcase
    end
  end

  assign bus.rdata       = r_rdata;
  assign clks_per_bit    = r_baud;
  assign ld_clks_per_bit = r_ld;
  assign irq             = r_irq;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios followed by
// random bus/receive traffic, all compared to a queue-based reference.
module tb_uart_rx_ctrl;
  import uart_ctrl_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic [31:0] clks_per_bit;
  logic        ld;
  logic        irq;

  uart_rx_ctrl_if bus();

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .i_Clock         (clk),
    .rst             (rst),
    .bus             (bus),
    .rx_dv           (rx_dv),
    .rx_byte         (rx_byte),
    .clks_per_bit    (clks_per_bit),
    .ld_clks_per_bit (ld),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: FIFO as a queue, controller as a few flags.
  logic [7:0]  q[$];
  bit          m_ovr, m_run, m_ld, m_en, m_ien, m_irq;
  logic [31:0] m_baud, m_rdata;

  task automatic model_tick(input bit r, input bit s, input bit w, input bit rd,
                            input logic [1:0] a, input logic [31:0] d,
                            input bit dv, input logic [7:0] b);
    bit irq_n, start, was_loading, ovr_set, wrs;
    logic [31:0] rv;
    if (r) begin
      q.delete();
      m_ovr = 0; m_run = 0; m_ld = 0; m_en = 0; m_ien = 0; m_irq = 0;
      m_baud = 32'd434; m_rdata = 32'd0;
      return;
    end
    irq_n       = m_ien && (q.size() != 0 || m_ovr);
    was_loading = m_ld;
    start       = 0;
    ovr_set     = 0;
    wrs         = s && w;
    if (s && rd) begin
      case (a)
        2'd0: rv = (q.size() != 0) ? {24'd0, q[0]} : 32'd0;
        2'd1: begin
          rv = 32'(q.size()) << 8;
          rv[3] = m_run; rv[2] = m_ovr;
          rv[1] = (q.size() == DEPTH); rv[0] = (q.size() != 0);
        end
        2'd2: rv = m_baud;
        default: rv = {30'd0, m_ien, m_en};
      endcase
      m_rdata = rv;
    end
    if (wrs && a == 2'd3 && d[2]) begin
      q.delete();
    end else begin
      if (s && rd && a == 2'd0 && q.size() != 0) void'(q.pop_front());
      if (dv && m_run) begin
        if (q.size() < DEPTH) q.push_back(b);
        else ovr_set = 1;
      end
    end
    if (ovr_set) m_ovr = 1;
    else if (wrs && a == 2'd1 && d[2]) m_ovr = 0;
    if (wrs && a == 2'd2 && d >= 32'd4) begin
      m_baud = d;
      if (m_run && !was_loading) start = 1;
    end
    if (wrs && a == 2'd3) begin
      m_en = d[0]; m_ien = d[1];
      if (!m_run && d[0]) start = 1;
      else if (m_run && !was_loading && !d[0]) m_run = 0;
    end
    m_irq = irq_n;
    m_ld  = start;
    if (start) m_run = 1;
  endtask

  // One clock: drive inputs, advance model, compare just after the edge.
  task automatic step(input bit r, input bit s, input bit w, input bit rd,
                      input logic [1:0] a, input logic [31:0] d,
                      input bit dv, input logic [7:0] b);
    rst = r; bus.sel = s; bus.wr = w; bus.rd = rd; bus.addr = a; bus.wdata = d;
    rx_dv = dv; rx_byte = b;
    model_tick(r, s, w, rd, a, d, dv, b);
    @(posedge clk); #1;
    check("rdata", bus.rdata, m_rdata);
    check("ld", 32'(ld), 32'(m_ld));
    check("clks_per_bit", clks_per_bit, m_baud);
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic idle();                                   step(0, 0, 0, 0, 2'd0, 0, 0, 8'h00); endtask
  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d); step(0, 1, 1, 0, a, d, 0, 8'h00); endtask
  task automatic rd_reg(input logic [1:0] a);              step(0, 1, 0, 1, a, 0, 0, 8'h00); endtask
  task automatic push(input logic [7:0] b);                step(0, 0, 0, 0, 2'd0, 0, 1, b); endtask

  initial begin
    rst = 1; bus.sel = 0; bus.wr = 0; bus.rd = 0; bus.addr = 0; bus.wdata = 0;
    rx_dv = 0; rx_byte = 0;

    // 1: reset state
    step(1, 0, 0, 0, 2'd0, 0, 0, 8'h00);
    step(1, 1, 1, 0, ADDR_CTRL, 32'h1, 1, 8'hFF);
    rd_reg(ADDR_BAUD);   check("t1_baud", bus.rdata, 32'd434);
    rd_reg(ADDR_STATUS); check("t1_status", bus.rdata, 32'd0);
    check("t1_irq", 32'(irq), 32'd0);

    // 2: baud stored while off, loaded on enable
    wr_reg(ADDR_BAUD, 32'd868);
    check("t2_no_ld", 32'(ld), 32'd0);
    wr_reg(ADDR_CTRL, 32'h1);
    check("t2_ld", 32'(ld), 32'd1);
    check("t2_cpb", clks_per_bit, 32'd868);
    idle();              check("t2_ld_once", 32'(ld), 32'd0);
    rd_reg(ADDR_STATUS); check("t2_running", 32'(bus.rdata[3]), 32'd1);

    // 3: capture, irq, pops, empty read
    wr_reg(ADDR_CTRL, 32'h3);
    push(8'hA5); push(8'h3C); idle();
    check("t3_irq", 32'(irq), 32'd1);
    rd_reg(ADDR_STATUS); check("t3_count", 32'(bus.rdata[15:8]), 32'd2);
    rd_reg(ADDR_DATA);   check("t3_pop1", bus.rdata, 32'hA5);
    rd_reg(ADDR_DATA);   check("t3_pop2", bus.rdata, 32'h3C);
    rd_reg(ADDR_DATA);   check("t3_empty", bus.rdata, 32'd0);
    check("t3_irq_low", 32'(irq), 32'd0);

    // 4: overflow and overrun clear
    for (int i = 1; i <= 9; i++) push(8'(i));
    rd_reg(ADDR_STATUS);
    check("t4_full", 32'(bus.rdata[1]), 32'd1);
    check("t4_ovr", 32'(bus.rdata[2]), 32'd1);
    wr_reg(ADDR_STATUS, 32'h4);
    rd_reg(ADDR_STATUS); check("t4_ovr_clr", 32'(bus.rdata[2]), 32'd0);
    rd_reg(ADDR_DATA);   check("t4_first", bus.rdata, 32'd1);

    // 5: pop+push on full, push+flush
    push(8'h55);
    step(0, 1, 0, 1, ADDR_DATA, 0, 1, 8'h66);
    check("t5_pop", bus.rdata, 32'd2);
    rd_reg(ADDR_STATUS);
    check("t5_count8", 32'(bus.rdata[15:8]), 32'd8);
    check("t5_no_ovr", 32'(bus.rdata[2]), 32'd0);
    step(0, 1, 1, 0, ADDR_CTRL, 32'h7, 1, 8'h77);
    rd_reg(ADDR_STATUS); check("t5_flushed", 32'(bus.rdata[15:8]), 32'd0);

    // 6: baud rules while running
    wr_reg(ADDR_BAUD, 32'd2);
    check("t6_ignored_ld", 32'(ld), 32'd0);
    rd_reg(ADDR_BAUD);   check("t6_baud_kept", bus.rdata, 32'd868);
    push(8'h11); push(8'h22);
    wr_reg(ADDR_BAUD, 32'd100);
    check("t6_ld", 32'(ld), 32'd1);
    check("t6_cpb", clks_per_bit, 32'd100);
    idle(); idle();
    rd_reg(ADDR_DATA);   check("t6_intact", bus.rdata, 32'h11);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      bit r, s, w, rdx, dv;
      logic [1:0] a;
      logic [31:0] d;
      r   = ($urandom_range(0, 599) == 0);
      s   = ($urandom_range(0, 3) != 0);
      w   = ($urandom_range(0, 9) < 3);
      rdx = ($urandom_range(0, 9) < 4);
      a   = 2'($urandom_range(0, 3));
      case (a)
        ADDR_CTRL: begin
          d = 32'd0;
          d[0] = ($urandom_range(0, 9) < 8);
          d[1] = $urandom_range(0, 1);
          d[2] = ($urandom_range(0, 7) == 0);
        end
        ADDR_BAUD: begin
          case ($urandom_range(0, 4))
            0: d = 32'd2;
            1: d = 32'd3;
            2: d = 32'd4;
            3: d = 32'd434;
            default: d = $urandom;
          endcase
        end
        ADDR_STATUS: d = 32'($urandom_range(0, 7));
        default:     d = $urandom;
      endcase
      dv = ($urandom_range(0, 99) < 35);
      step(r, s, w, rdx, a, d, dv, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
